// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one RAM read port between NUM_REQ requesters with round-robin grants, burst locking and tagged response routing
module ram_read_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0]                req_last_i,
    input  logic [NUM_REQ*$clog2(DEPTH)-1:0]  req_addr_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                resp_valid_o,
    output logic [WIDTH-1:0]                  resp_data_o,
    output logic                              ram_read_o,
    output logic [$clog2(DEPTH)-1:0]          ram_addrb_o,
    input  logic [WIDTH-1:0]                  ram_doutb_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [AW-1:0]     addr_q;
    logic [NUM_REQ-1:0] pipe_q [READ_LATENCY];
    logic [IW-1:0]     win;
    logic              found;
    logic              accept;
    int                idx;

    // Pick the winner: burst owner when locked, else first valid requester from the RR pointer
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state_q == BURST) begin
            found = req_valid_i[owner_q];
            win   = owner_q;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                idx = (int'(ptr_q) + j) % NUM_REQ;
                if (!found && req_valid_i[IW'(idx)]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
        end
        accept      = found && rst_n;
        req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
        ram_read_o  = accept;
        ram_addrb_o = accept ? req_addr_i[int'(win)*AW +: AW] : addr_q;
        state_d     = !accept ? state_q : (req_last_i[win] ? IDLE : BURST);
        ptr_d       = (state_q == IDLE && accept) ? ((int'(win) == NUM_REQ-1) ? '0 : win + 1'b1) : ptr_q;
        owner_d     = (state_q == IDLE && accept) ? win : owner_q;
    end

    // Arbiter state, held RAM address and response tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            addr_q    <= ram_addrb_o;
            pipe_q[0] <= req_ready_o;
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign resp_valid_o = pipe_q[READ_LATENCY-1];
    assign resp_data_o  = ram_doutb_i;

endmodule
